// File: rtl/dice_roll_ctrl.sv
// Roll sequencer and craps game controller for the dual-dice sum counter.
// Optional macro DICE_SCORE_EN adds saturating wins/losses score outputs.
module dice_roll_ctrl #(
  parameter int MIN_ROLL_CYCLES = 16,
  parameter int HOLD_W          = 8
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       roll,
  input  logic [3:0] sum,
  output logic       cnt_enable,
  output logic       busy,
  output logic [3:0] last_sum,
  output logic [3:0] point,
  output logic       point_valid,
  output logic       win,
`ifdef DICE_SCORE_EN
  output logic       lose,
  output logic [7:0] wins,
  output logic [7:0] losses
`else
  output logic       lose
`endif
);

  localparam logic [HOLD_W-1:0] HOLD_MIN = HOLD_W'(MIN_ROLL_CYCLES);
  localparam logic [HOLD_W-1:0] HOLD_MAX = '1;

  typedef enum logic [2:0] {IDLE, ROLL, SETTLE, POINT, WIN, LOSE} state_t;

  state_t            state_reg;
  logic              roll_q;
  logic              armed_reg;
  logic [HOLD_W-1:0] hold_cnt;

  logic rise;
  logic sum_legal;
  logic sum_natural;
  logic sum_craps;
  logic settle_win;
  logic settle_lose;

  // armed_reg keeps a button still held through reset from starting a roll
  assign rise = roll & ~roll_q & armed_reg;

  assign cnt_enable = (state_reg == ROLL);
  assign busy       = (state_reg == ROLL) || (state_reg == SETTLE);

  always_comb begin
    sum_legal   = (sum >= 4'd2) && (sum <= 4'd12);
    sum_natural = (sum == 4'd7) || (sum == 4'd11);
    sum_craps   = (sum == 4'd2) || (sum == 4'd3) || (sum == 4'd12);
    settle_win  = 1'b0;
    settle_lose = 1'b0;
    if (state_reg == SETTLE && sum_legal) begin
      if (point_valid) begin
        settle_win  = (sum == point);
        settle_lose = (sum == 4'd7);
      end else begin
        settle_win  = sum_natural;
        settle_lose = sum_craps;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg   <= IDLE;
      roll_q      <= 1'b0;
      armed_reg   <= 1'b0;
      hold_cnt    <= '0;
      last_sum    <= 4'd0;
      point       <= 4'd0;
      point_valid <= 1'b0;
      win         <= 1'b0;
      lose        <= 1'b0;
    end else begin
      roll_q <= roll;
      if (!roll) begin
        armed_reg <= 1'b1;
      end
      case (state_reg)
        IDLE, POINT: begin
          if (rise) begin
            state_reg <= ROLL;
            hold_cnt  <= HOLD_W'(1);
          end
        end
        WIN, LOSE: begin
          if (rise) begin
            state_reg   <= ROLL;
            hold_cnt    <= HOLD_W'(1);
            win         <= 1'b0;
            lose        <= 1'b0;
            point       <= 4'd0;
            point_valid <= 1'b0;
          end
        end
        ROLL: begin
          if (hold_cnt != HOLD_MAX) begin
            hold_cnt <= hold_cnt + HOLD_W'(1);
          end
          if (!roll && hold_cnt >= HOLD_MIN) begin
            state_reg <= SETTLE;
          end
        end
        SETTLE: begin
          last_sum <= sum;
          if (settle_win) begin
            state_reg <= WIN;
            win       <= 1'b1;
          end else if (settle_lose) begin
            state_reg <= LOSE;
            lose      <= 1'b1;
          end else if (sum_legal && !point_valid) begin
            state_reg   <= POINT;
            point       <= sum;
            point_valid <= 1'b1;
          end else begin
            state_reg <= point_valid ? POINT : IDLE;
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

`ifdef DICE_SCORE_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      wins   <= 8'd0;
      losses <= 8'd0;
    end else begin
      if (settle_win && wins != 8'hFF) begin
        wins <= wins + 8'd1;
      end
      if (settle_lose && losses != 8'hFF) begin
        losses <= losses + 8'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_dice_roll_ctrl.sv
// Randomised self-checking bench for dice_roll_ctrl against a per-roll game model.
module tb_dice_roll_ctrl;

  localparam int MIN = 16;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       roll = 1'b0;
  logic [3:0] sum;
  logic       cnt_enable, busy, point_valid, win, lose;
  logic [3:0] last_sum, point;
`ifdef DICE_SCORE_EN
  logic [7:0] wins, losses;
`endif

  logic       force_en = 1'b0;
  logic [3:0] force_val = 4'd0;
  logic [3:0] ctr;

  int en_total = 0;
  int busy_total = 0;

  int m_point, m_pv, m_win, m_lose, m_last, m_wins, m_losses;
  int n_checks = 0;
  int n_fail = 0;

  dice_roll_ctrl #(.MIN_ROLL_CYCLES(MIN), .HOLD_W(8)) dut (
    .clk(clk), .reset(reset), .roll(roll), .sum(sum),
    .cnt_enable(cnt_enable), .busy(busy), .last_sum(last_sum),
    .point(point), .point_valid(point_valid), .win(win),
`ifdef DICE_SCORE_EN
    .lose(lose), .wins(wins), .losses(losses)
`else
    .lose(lose)
`endif
  );

  always #5 clk = ~clk;

  // Free-running 2..12 dice counter, overridable to force a chosen sum
  always @(posedge clk) begin
    if (reset) ctr <= 4'd2;
    else if (cnt_enable) ctr <= (ctr == 4'd12) ? 4'd2 : ctr + 4'd1;
  end
  assign sum = force_en ? force_val : ctr;

  always @(negedge clk) begin
    if (cnt_enable) en_total <= en_total + 1;
    if (busy) busy_total <= busy_total + 1;
  end

  task automatic check_eq(input string tag, input int obs, input int exp);
    n_checks++;
    if (obs != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic void model_clear_all();
    m_point = 0; m_pv = 0; m_win = 0; m_lose = 0; m_last = 0;
    m_wins = 0; m_losses = 0;
  endfunction

  function automatic void model_new_game();
    if (m_win != 0 || m_lose != 0) begin
      m_win = 0; m_lose = 0; m_point = 0; m_pv = 0;
    end
  endfunction

  function automatic void model_capture(input int s);
    bit w, l;
    w = 0; l = 0;
    m_last = s;
    if (s >= 2 && s <= 12) begin
      if (m_pv == 0) begin
        if (s == 7 || s == 11) w = 1;
        else if (s == 2 || s == 3 || s == 12) l = 1;
        else begin m_pv = 1; m_point = s; end
      end else begin
        if (s == m_point) w = 1;
        else if (s == 7) l = 1;
      end
    end
    if (w) begin m_win = 1; if (m_wins < 255) m_wins++; end
    if (l) begin m_lose = 1; if (m_losses < 255) m_losses++; end
  endfunction

  task automatic check_outputs(input string tag);
    check_eq({tag, ".last_sum"}, int'(last_sum), m_last);
    check_eq({tag, ".point"}, int'(point), m_point);
    check_eq({tag, ".point_valid"}, int'(point_valid), m_pv);
    check_eq({tag, ".win"}, int'(win), m_win);
    check_eq({tag, ".lose"}, int'(lose), m_lose);
    check_eq({tag, ".cnt_enable"}, int'(cnt_enable), 0);
    check_eq({tag, ".busy"}, int'(busy), 0);
`ifdef DICE_SCORE_EN
    check_eq({tag, ".wins"}, int'(wins), m_wins);
    check_eq({tag, ".losses"}, int'(losses), m_losses);
`endif
  endtask

  // One roll: press for len cycles, settle, compare against the model.
  // fsum < 0 lets the counter supply the sum.
  task automatic do_roll(input int len, input int fsum, input bit verbose);
    int c0, e0, b0, n, s;
    bit done;
    if (fsum >= 0) begin force_en = 1'b1; force_val = 4'(fsum); end
    else force_en = 1'b0;
    c0 = int'(ctr); e0 = en_total; b0 = busy_total;
    roll = 1'b1;
    @(posedge clk); #1;
    model_new_game();
    check_eq("rise.busy", int'(busy), 1);
    check_eq("rise.win", int'(win), m_win);
    check_eq("rise.lose", int'(lose), m_lose);
    check_eq("rise.point_valid", int'(point_valid), m_pv);
    for (int k = 1; k < len; k++) begin
      @(posedge clk); #1;
    end
    roll = 1'b0;
    done = 1'b0;
    for (int k = 0; k < 100; k++) begin
      if (!busy) begin done = 1'b1; break; end
      @(posedge clk); #1;
    end
    check_eq("settle_timeout", int'(done), 1);
    n = (len > MIN) ? len : MIN;
    s = (fsum >= 0) ? fsum : 2 + (c0 - 2 + n) % 11;
    model_capture(s);
    check_eq("enable_cycles", en_total - e0, n);
    check_eq("busy_cycles", busy_total - b0, n + 1);
    check_outputs("roll");
    if (verbose)
      $display("roll len=%0d sum=%0d last_sum=%0d point=%0d pv=%0d win=%0d lose=%0d",
               len, s, last_sum, point, point_valid, win, lose);
    repeat ($urandom_range(0, 3)) @(posedge clk);
    #1;
  endtask

  task automatic reset_mid_roll();
    int bcount;
    roll = 1'b1;
    @(posedge clk); #1;
    repeat (19) @(posedge clk);
    #1;
    check_eq("pre_reset.cnt_enable", int'(cnt_enable), 1);
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    model_clear_all();
    check_outputs("mid_reset");
    bcount = 0;
    for (int k = 0; k < 10; k++) begin
      @(posedge clk); #1;
      if (busy) bcount++;
    end
    check_eq("held_after_reset.busy_cycles", bcount, 0);
    roll = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    $display("reset mid-roll: outputs cleared, held button ignored");
  endtask

  initial begin
    model_clear_all();
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;
    check_outputs("reset");
    @(posedge clk); #1;

    do_roll(2, -1, 1'b1);               // short press, counter-driven sum
    do_roll(3, 7, 1'b1);                // naturals and craps
    do_roll(3, 11, 1'b1);
    do_roll(3, 2, 1'b1);
    do_roll(3, 3, 1'b1);
    do_roll(3, 12, 1'b1);
    do_roll(4, 6, 1'b1);                // point sequence
    do_roll(4, 9, 1'b1);
    do_roll(4, 6, 1'b1);
    do_roll(5, 4, 1'b1);                // seven-out
    do_roll(5, 7, 1'b1);
    do_roll(3, 5, 1'b1);                // rise clears the lost game
    do_roll(3, 7, 1'b1);
    do_roll(3, 13, 1'b1);               // illegal sum with no point
    do_roll(40, -1, 1'b1);              // long press
    do_roll(17, 0, 1'b1);

    reset_mid_roll();
    do_roll(2, -1, 1'b1);

    for (int i = 0; i < 80; i++) begin
      int len, fs;
      len = $urandom_range(1, 40);
      fs = ($urandom_range(0, 1) == 1) ? int'($urandom_range(0, 15)) : -1;
      do_roll(len, fs, 1'b1);
    end

`ifdef DICE_SCORE_EN
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    model_clear_all();
    @(posedge clk); #1;
    for (int i = 0; i < 257; i++) begin
      do_roll(1, 7, (i >= 254));
    end
    check_eq("wins_saturated", int'(wins), 255);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
